// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: branch resolution and architectural PC register for a
// single-cycle RV32I core. Decodes the branch funct3, selects unsigned
// comparison, resolves B-type/JAL/JALR, and sequences BOOT/RUN/TRAP with a
// misaligned-target trap redirect.
// Optional macro BR_PERF_CNT_EN: enables branch / taken-branch counters on
// o_br_cnt / o_br_taken_cnt; when undefined those ports are tied to zero.
module pc_branch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_funct3,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic [31:0] i_target,
    output logic        o_br_un,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_insn_vld,
    output logic        o_taken,
    output logic        o_illegal_br,
    output logic        o_misalign,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_br_taken_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        r_misalign;
    logic        w_next_misalign;

    logic        w_cond;
    logic        w_br_taken;
    logic        w_cond_taken;
    logic [31:0] w_eff_target;
    logic        w_misalign;
    logic        w_advance;

    // Branch condition decode from funct3 and comparator flags
    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            3'b000:  w_cond = i_br_equal;
            3'b001:  w_cond = ~i_br_equal;
            3'b100:  w_cond = i_br_less;
            3'b101:  w_cond = ~i_br_less;
            3'b110:  w_cond = i_br_less;
            3'b111:  w_cond = ~i_br_less;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_br_un      = i_funct3[1];
    assign o_illegal_br = i_is_branch & (i_funct3[2:1] == 2'b01);
    assign w_br_taken   = i_is_branch & w_cond;
    assign w_cond_taken = w_br_taken | i_is_jal | i_is_jalr;
    assign o_insn_vld   = (r_state == ST_RUN);
    assign w_advance    = o_insn_vld & ~i_stall;
    assign o_taken      = w_cond_taken & w_advance;
    assign w_eff_target = i_is_jalr ? {i_target[31:1], 1'b0} : i_target;
    assign w_misalign   = o_taken & (w_eff_target[1:0] != 2'b00);
    assign o_pc         = r_pc;
    assign o_pc_four    = r_pc + 32'd4;
    assign o_misalign   = r_misalign;

    // Next-state / next-PC selection; BOOT and TRAP each last one cycle and ignore stall
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_misalign = 1'b0;
        case (r_state)
            ST_BOOT: w_next_state = ST_RUN;
            ST_TRAP: w_next_state = ST_RUN;
            ST_RUN: begin
                if (!i_stall) begin
                    if (w_misalign) begin
                        w_next_pc       = TRAP_VEC;
                        w_next_misalign = 1'b1;
                        w_next_state    = ST_TRAP;
                    end else if (o_taken) begin
                        w_next_pc = w_eff_target;
                    end else begin
                        w_next_pc = o_pc_four;
                    end
                end
            end
            default: w_next_state = ST_BOOT;
        endcase
    end

    // State, PC and trap-pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= w_next_misalign;
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_br_taken_cnt;

    // Count executed B-type instructions and those that were taken (jumps excluded)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_br_cnt       <= '0;
            r_br_taken_cnt <= '0;
        end else if (w_advance && i_is_branch) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_br_taken) begin
                r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
            end
        end
    end

    assign o_br_cnt       = r_br_cnt;
    assign o_br_taken_cnt = r_br_taken_cnt;
`else
    assign o_br_cnt       = '0;
    assign o_br_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed self-checking bench for pc_branch_ctrl.
module tb_pc_branch_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_is_branch;
    logic        i_is_jal;
    logic        i_is_jalr;
    logic [2:0]  i_funct3;
    logic        i_br_less;
    logic        i_br_equal;
    logic [31:0] i_target;
    logic        o_br_un;
    logic [31:0] o_pc;
    logic [31:0] o_pc_four;
    logic        o_insn_vld;
    logic        o_taken;
    logic        o_illegal_br;
    logic        o_misalign;
    logic [31:0] o_br_cnt;
    logic [31:0] o_br_taken_cnt;

    int checks = 0;
    int errors = 0;

    pc_branch_ctrl #(
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_stall        (i_stall),
        .i_is_branch    (i_is_branch),
        .i_is_jal       (i_is_jal),
        .i_is_jalr      (i_is_jalr),
        .i_funct3       (i_funct3),
        .i_br_less      (i_br_less),
        .i_br_equal     (i_br_equal),
        .i_target       (i_target),
        .o_br_un        (o_br_un),
        .o_pc           (o_pc),
        .o_pc_four      (o_pc_four),
        .o_insn_vld     (o_insn_vld),
        .o_taken        (o_taken),
        .o_illegal_br   (o_illegal_br),
        .o_misalign     (o_misalign),
        .o_br_cnt       (o_br_cnt),
        .o_br_taken_cnt (o_br_taken_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic idle();
        i_stall     = 1'b0;
        i_is_branch = 1'b0;
        i_is_jal    = 1'b0;
        i_is_jalr   = 1'b0;
        i_funct3    = 3'b000;
        i_br_less   = 1'b0;
        i_br_equal  = 1'b0;
        i_target    = 32'h0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_funct3 = 3'b010;
        #1;
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", o_pc, 32'h0); end
        checks++; if (o_insn_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", o_insn_vld); end
        checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", o_misalign); end
        checks++; if (o_br_un !== 1'b1) begin errors++; $display("FAIL rst_brun got %b exp 1", o_br_un); end
        checks++; if (o_br_cnt !== 32'h0) begin errors++; $display("FAIL rst_brcnt got %h exp 0", o_br_cnt); end
        i_funct3 = 3'b000;
    endtask

    task automatic test_boot_seq();
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        checks++; if (o_insn_vld !== 1'b0) begin errors++; $display("FAIL boot_vld got %b exp 0", o_insn_vld); end
        tick();
        checks++; if (o_insn_vld !== 1'b1) begin errors++; $display("FAIL run_vld got %b exp 1", o_insn_vld); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL boot_pc got %h exp %h", o_pc, 32'h0); end
        checks++; if (o_pc_four !== 32'h4) begin errors++; $display("FAIL pc_four got %h exp %h", o_pc_four, 32'h4); end
        tick();
        checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got %h exp %h", o_pc, 32'h4); end
        tick();
        checks++; if (o_pc !== 32'h8) begin errors++; $display("FAIL seq_pc8 got %h exp %h", o_pc, 32'h8); end
    endtask

    task automatic test_branch();
        i_is_branch = 1'b1; i_funct3 = 3'b110; i_br_less = 1'b1; i_target = 32'h40;
        #1;
        checks++; if (o_br_un !== 1'b1) begin errors++; $display("FAIL bltu_un got %b exp 1", o_br_un); end
        checks++; if (o_taken !== 1'b1) begin errors++; $display("FAIL bltu_taken got %b exp 1", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h40) begin errors++; $display("FAIL bltu_pc got %h exp %h", o_pc, 32'h40); end
        i_funct3 = 3'b101; i_target = 32'h80;
        #1;
        checks++; if (o_br_un !== 1'b0) begin errors++; $display("FAIL bge_un got %b exp 0", o_br_un); end
        checks++; if (o_taken !== 1'b0) begin errors++; $display("FAIL bge_taken got %b exp 0", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h44) begin errors++; $display("FAIL bge_pc got %h exp %h", o_pc, 32'h44); end
        idle();
    endtask

    task automatic test_jalr_misalign();
        i_is_jalr = 1'b1; i_target = 32'h203;
        #1;
        checks++; if (o_taken !== 1'b1) begin errors++; $display("FAIL jalr_taken got %b exp 1", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL trap_pc got %h exp %h", o_pc, 32'h100); end
        checks++; if (o_misalign !== 1'b1) begin errors++; $display("FAIL trap_mis got %b exp 1", o_misalign); end
        checks++; if (o_insn_vld !== 1'b0) begin errors++; $display("FAIL trap_vld got %b exp 0", o_insn_vld); end
        checks++; if (o_taken !== 1'b0) begin errors++; $display("FAIL trap_taken got %b exp 0", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL post_trap_pc got %h exp %h", o_pc, 32'h100); end
        checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL post_trap_mis got %b exp 0", o_misalign); end
        checks++; if (o_insn_vld !== 1'b1) begin errors++; $display("FAIL post_trap_vld got %b exp 1", o_insn_vld); end
        i_target = 32'h205;
        tick();
        checks++; if (o_pc !== 32'h204) begin errors++; $display("FAIL jalr_pc got %h exp %h", o_pc, 32'h204); end
        checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL jalr_mis got %b exp 0", o_misalign); end
        idle();
    endtask

    task automatic test_stall();
        i_is_branch = 1'b1; i_funct3 = 3'b000; i_br_equal = 1'b1; i_target = 32'h80; i_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (o_taken !== 1'b0) begin errors++; $display("FAIL stall_taken%0d got %b exp 0", n, o_taken); end
            tick();
            checks++; if (o_pc !== 32'h204) begin errors++; $display("FAIL stall_pc%0d got %h exp %h", n, o_pc, 32'h204); end
        end
        i_stall = 1'b0;
        #1;
        checks++; if (o_taken !== 1'b1) begin errors++; $display("FAIL unstall_taken got %b exp 1", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h80) begin errors++; $display("FAIL unstall_pc got %h exp %h", o_pc, 32'h80); end
        idle();
    endtask

    task automatic test_illegal_wrap();
        i_is_branch = 1'b1; i_funct3 = 3'b010; i_br_equal = 1'b1; i_br_less = 1'b1; i_target = 32'h40;
        #1;
        checks++; if (o_illegal_br !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b exp 1", o_illegal_br); end
        checks++; if (o_taken !== 1'b0) begin errors++; $display("FAIL illegal_taken got %b exp 0", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h84) begin errors++; $display("FAIL illegal_pc got %h exp %h", o_pc, 32'h84); end
        idle();
        #1;
        checks++; if (o_illegal_br !== 1'b0) begin errors++; $display("FAIL legal_flag got %b exp 0", o_illegal_br); end
        i_is_jal = 1'b1; i_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_top_pc got %h exp %h", o_pc, 32'hFFFF_FFFC); end
        idle();
        #1;
        checks++; if (o_pc_four !== 32'h0) begin errors++; $display("FAIL wrap_four got %h exp 0", o_pc_four); end
        tick();
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", o_pc); end
        checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL wrap_mis got %b exp 0", o_misalign); end
    endtask

    task automatic test_multi_select();
        i_is_branch = 1'b1; i_is_jalr = 1'b1; i_funct3 = 3'b001; i_br_equal = 1'b1; i_target = 32'h1001;
        #1;
        checks++; if (o_taken !== 1'b1) begin errors++; $display("FAIL multi_taken got %b exp 1", o_taken); end
        tick();
        checks++; if (o_pc !== 32'h1000) begin errors++; $display("FAIL multi_pc got %h exp %h", o_pc, 32'h1000); end
        idle();
    endtask

    task automatic test_counters_async_reset();
        logic [31:0] exp_br;
        logic [31:0] exp_tk;
        #3 i_rst = 1'b1;
        #1;
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", o_pc); end
        checks++; if (o_insn_vld !== 1'b0) begin errors++; $display("FAIL arst_vld got %b exp 0", o_insn_vld); end
        checks++; if (o_br_cnt !== 32'h0 || o_br_taken_cnt !== 32'h0) begin errors++; $display("FAIL arst_cnt got %h/%h exp 0/0", o_br_cnt, o_br_taken_cnt); end
        tick();
        i_rst = 1'b0;
        tick();
        i_is_branch = 1'b1; i_funct3 = 3'b000; i_br_equal = 1'b1; i_target = 32'h100; tick();
        idle(); i_is_jal = 1'b1; i_target = 32'h200; tick();
        idle(); i_is_branch = 1'b1; i_funct3 = 3'b001; i_br_equal = 1'b1; i_target = 32'h900; tick();
        idle(); i_is_branch = 1'b1; i_funct3 = 3'b100; i_br_less = 1'b1; i_target = 32'h300; i_stall = 1'b1; tick();
        i_stall = 1'b0; tick();
        idle(); i_is_jal = 1'b1; i_target = 32'h400; tick();
        idle(); i_is_branch = 1'b1; i_funct3 = 3'b111; i_br_less = 1'b0; i_target = 32'h500; tick();
        idle(); i_is_branch = 1'b1; i_funct3 = 3'b110; i_br_less = 1'b0; i_target = 32'h700; tick();
        idle();
        checks++; if (o_pc !== 32'h504) begin errors++; $display("FAIL cnt_pc got %h exp %h", o_pc, 32'h504); end
`ifdef BR_PERF_CNT_EN
        exp_br = 32'd5;
        exp_tk = 32'd3;
`else
        exp_br = 32'd0;
        exp_tk = 32'd0;
`endif
        checks++; if (o_br_cnt !== exp_br) begin errors++; $display("FAIL br_cnt got %0d exp %0d", o_br_cnt, exp_br); end
        checks++; if (o_br_taken_cnt !== exp_tk) begin errors++; $display("FAIL br_taken_cnt got %0d exp %0d", o_br_taken_cnt, exp_tk); end
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        #11;
        test_reset();
        test_boot_seq();
        test_branch();
        test_jalr_misalign();
        test_stall();
        test_illegal_wrap();
        test_multi_select();
        test_counters_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Stage directly downstream of the branch comparator in the single-cycle RV32I core.
- Decodes the branch funct3 and drives the comparator's unsigned-select input.
- Consumes the less/equal flags and resolves taken/not-taken for B-type, JAL and JALR.
- Owns the architectural PC register, with boot sequencing, stall hold and a misaligned-target trap redirect.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned taken control transfer

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_stall  input  1  hold PC and suppress resolution this cycle
i_is_branch  input  1  current instruction is B-type
i_is_jal  input  1  current instruction is JAL
i_is_jalr  input  1  current instruction is JALR
i_funct3  input  3  instruction funct3
i_br_less  input  1  comparator less flag
i_br_equal  input  1  comparator equal flag
i_target  input  32  ALU-computed target (pc+imm or rs1+imm)
o_br_un  output  1  to comparator i_br_un; equals i_funct3[1] (combinational)
o_pc  output  32  current PC register
o_pc_four  output  32  o_pc + 4 (combinational, mod 2^32)
o_insn_vld  output  1  instruction at o_pc is valid to execute
o_taken  output  1  control transfer taken this cycle (combinational)
o_illegal_br  output  1  B-type with funct3 010/011 (combinational)
o_misalign  output  1  registered one-cycle pulse: misaligned target trapped

Behaviour:
- Reset (async, any state): o_pc=RESET_VEC, state=BOOT, o_insn_vld=0, o_misalign=0. Combinational outputs depend on inputs only.
- FSM states BOOT, RUN, TRAP; o_insn_vld=1 only in RUN.
- BOOT: one cycle, PC unchanged, then RUN. i_stall ignored.
- TRAP: one cycle, PC holds TRAP_VEC, then RUN. i_stall ignored.
- Branch conditions, evaluated only when i_is_branch:
  - 000 BEQ: equal
  - 001 BNE: !equal
  - 100 BLT: less
  - 101 BGE: !less
  - 110 BLTU: less
  - 111 BGEU: !less
  - 010/011: not taken, o_illegal_br=1
- o_br_un = i_funct3[1] at all times; the comparator returns flags in the same cycle.
- cond_taken = (i_is_branch & cond) | i_is_jal | i_is_jalr.
- o_taken = cond_taken & o_insn_vld & !i_stall.
- Effective target: {i_target[31:1],1'b0} for JALR, i_target otherwise.
- misalign = o_taken & (eff_target[1:0] != 0). Not-taken branches never trap.
- Next PC in RUN with !i_stall:
  - misalign: PC=TRAP_VEC, o_misalign=1 next cycle, state=TRAP
  - else o_taken: PC=eff_target
  - else: PC=o_pc_four
- RUN with i_stall: PC, state and o_misalign=0 hold. A stall coincident with a taken or misaligned transfer suppresses both.
- o_misalign is high exactly one cycle (the TRAP cycle), else 0.
- More than one of i_is_branch/i_is_jal/i_is_jalr set: the jump wins (taken); decoder guarantees exclusivity, but the block must not X-propagate.
- Wrap-around: PC 32'hFFFF_FFFC not taken -> 32'h0000_0000; no flag.
- Latency: resolution is combinational; PC update is one clock.

Optional Feature:
- Macro BR_PERF_CNT_EN.
- Defined: adds outputs o_br_cnt[31:0] and o_br_taken_cnt[31:0], reset to 0.
  - o_br_cnt increments on each RUN, !i_stall cycle with i_is_branch (including illegal funct3).
  - o_br_taken_cnt increments when that branch is taken (misaligned included).
  - Both wrap modulo 2^32. Jumps are not counted.
- Undefined: ports exist but are tied to 0; no counter flops.

Test Plan:
- Reset release -> o_pc=0x0, o_insn_vld=0 one cycle (BOOT), then 1. With no transfers, o_pc steps 0x0 -> 0x4 -> 0x8.
- BLTU (funct3 110), less=1, i_target=0x40 at PC 0x8 -> o_br_un=1, o_taken=1, next o_pc=0x40. BGE (101), less=1 -> not taken, next o_pc=PC+4.
- JALR with i_target=0x203 -> effective 0x202, misaligned -> next o_pc=0x100, o_misalign=1 and o_insn_vld=0 for one cycle, then RUN at 0x100. JALR to 0x205 -> 0x204, no trap.
- BEQ taken (equal=1, target 0x80) with i_stall=1 for 3 cycles -> o_pc holds, o_taken=0. On the first unstalled cycle o_pc -> 0x80.
- Branch funct3=010 -> o_illegal_br=1, not taken, PC+4. PC 0xFFFF_FFFC sequential -> 0x0000_0000.
- With BR_PERF_CNT_EN: 5 branches (3 taken, 1 stalled extra cycle), 2 JALs -> o_br_cnt=5, o_br_taken_cnt=3. Async i_rst mid-run -> all counters and PC reset immediately.
